program_loader: RTL and testbench

Byte-stream program loader that writes 32-bit instruction words into the instruction memory's write port and holds the CPU in reset until the image is complete. It sits between an external byte source (UART receiver or bench driver) and the instruction memory. It is the writer side of the word-addressed read interface the fetch stage uses: word i lands at byte address 4·i and reads back unchanged.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader_byte_assembler.sv | 49 ++++
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } loader_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_BYTES_LOG2 = 2;

    // States in which a stream byte can be consumed.
    function automatic logic is_ready_state(input loader_state_t s);
        return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CHK);
    endfunction

    function automatic logic is_busy_state(input loader_state_t s);
        return !((s == IDLE) || (s == DONE) || (s == ERR));
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Collects four little-endian stream bytes into one 32-bit word; the first
// byte lands in bits [7:0]. word_valid is high the cycle after the 4th byte.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    logic [WORD_BYTES_LOG2-1:0] count_reg;
    logic                       word_valid_reg;

    assign last_byte  = (count_reg == WORD_BYTES_LOG2'(BYTES_PER_WORD - 1));
    assign word_valid = word_valid_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg      <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= byte_valid && last_byte;
            if (byte_valid) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // One lane register per byte position, loaded when the counter points at it.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (srst || clear) begin
                lane_reg <= '0;
            end else if (byte_valid && (count_reg == WORD_BYTES_LOG2'(gi))) begin
                lane_reg <= byte_data;
            end
        end

        assign word[8*gi +: 8] = lane_reg;
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: header count, N little-endian words written to
// instruction memory, CPU held in reset until done. Optional LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LAST = CHK;
`else
    localparam loader_state_t AFTER_LAST = DONE;
`endif

    loader_state_t       state_reg;
    loader_state_t       state_next;
    logic [15:0]         count_reg;
    logic [ADDR_WIDTH:0] index_reg;
    logic [31:0]         addr_reg;
    logic [31:0]         wdata_reg;

    logic        accept;
    logic        launch;
    logic        asm_byte_valid;
    logic        asm_last;
    logic        asm_word_valid;
    logic [31:0] asm_word;
    logic [31:0] write_addr;
    logic [15:0] hdr_count;
    logic        last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_reg;
`endif

    assign in_ready  = is_ready_state(state_reg);
    assign busy      = is_busy_state(state_reg);
    assign done      = (state_reg == DONE);
    assign error     = (state_reg == ERR);
    assign cpu_reset = (state_reg != DONE);

    assign accept         = in_valid && in_ready;
    assign launch         = start && !busy;
    assign asm_byte_valid = accept && (state_reg == DATA);

    // Full count as it will be once the high header byte is captured.
    assign hdr_count  = {in_data, count_reg[7:0]};
    assign write_addr = 32'({index_reg[ADDR_WIDTH-1:0], 2'b00});
    assign last_word  = ((32'(index_reg) + 32'd1) == {16'd0, count_reg});

    assign mem_we    = (state_reg == WRITE) && asm_word_valid;
    assign mem_addr  = mem_we ? write_addr : addr_reg;
    assign mem_wdata = mem_we ? asm_word : wdata_reg;

    byte_assembler u_assembler (
        .clk        (clk),
        .srst       (reset),
        .clear      (launch),
        .byte_valid (asm_byte_valid),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .last_byte  (asm_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR0;
                end
            end
            HDR0: begin
                if (accept) begin
                    state_next = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    if (hdr_count == 16'd0) begin
                        state_next = AFTER_LAST;
                    end else if ({16'd0, hdr_count} > MAX_WORDS) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && asm_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? AFTER_LAST : DATA;
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    state_next = (in_data == xor_reg) ? DONE : ERR;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            index_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                index_reg <= '0;
            end
            if (accept && (state_reg == HDR0)) begin
                count_reg[7:0] <= in_data;
            end
            if (accept && (state_reg == HDR1)) begin
                count_reg[15:8] <= in_data;
            end
            // Address and data stay visible after the strobe drops.
            if (mem_we) begin
                index_reg <= index_reg + 1'b1;
                addr_reg  <= write_addr;
                wdata_reg <= asm_word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over data bytes only; the header is excluded.
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            xor_reg <= '0;
        end else if (asm_byte_valid) begin
            xor_reg <= xor_reg ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads plus hand-written
// corner sequences; writes are checked against a scoreboard queue.
module tb_program_loader;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_reset (cpu_reset)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [15:0]       n;
        logic [3:0][31:0]  words;
        logic              gap;
        logic              exp_done;
        logic [2:0]        exp_writes;
    } vec_t;

    wr_t         sb[$];
    logic [31:0] wq[$];
    logic [31:0] mem_model [0:(1<<AW)-1];
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            writes++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
            end
            mem_model[mem_addr[AW+1:2]] = mem_wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("in_ready_wait");
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends header n and the first n words of wq; pushes expected writes.
    task automatic send_stream(input logic [15:0] n, input bit gap, input bit bad_chk);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = wq[i][8*k +: 8];
                x = x ^ b;
                if (k == 3) sb.push_back('{addr: 32'(i * 4), data: wq[i]});
                send_byte(b, gap);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, bad_chk}, gap);
`else
        if (bad_chk) $display("note: no checksum byte in this build (xor %h)", x);
`endif
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) fail_now("busy_wait");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        vecs[0] = '{n: 16'd2, words: {32'h0, 32'h0, 32'hE2811001, 32'hE3A00000},
                    gap: 1'b0, exp_done: 1'b1, exp_writes: 3'd2};
        vecs[1] = '{n: 16'd3, words: {32'h0, 32'hEAFFFFFE, 32'hE3A01005, 32'hE59F0010},
                    gap: 1'b1, exp_done: 1'b1, exp_writes: 3'd3};
        vecs[2] = '{n: 16'd0, words: '0,
                    gap: 1'b0, exp_done: 1'b1, exp_writes: 3'd0};
        vecs[3] = '{n: 16'd1, words: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                    gap: 1'b1, exp_done: 1'b1, exp_writes: 3'd1};
        vecs[4] = '{n: 16'd4, words: {32'h00000000, 32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567},
                    gap: 1'b0, exp_done: 1'b1, exp_writes: 3'd4};

        for (int v = 0; v < 5; v++) begin
            wq = {};
            for (int i = 0; i < 4; i++) wq.push_back(vecs[v].words[i]);
            w0 = writes;
            pulse_start();
            check("start_busy", 32'(busy), 32'd1);
            check("start_clears_done", 32'(done), 32'd0);
            send_stream(vecs[v].n, vecs[v].gap, 1'b0);
            wait_idle();
            check("load_done", 32'(done), 32'(vecs[v].exp_done));
            check("load_error", 32'(error), 32'd0);
            check("load_cpu_reset", 32'(cpu_reset), 32'(!vecs[v].exp_done));
            check("load_write_count", 32'(writes - w0), 32'(vecs[v].exp_writes));
            check("load_sb_empty", 32'(sb.size()), 32'd0);
            for (int i = 0; i < int'(vecs[v].n); i++)
                check("mem_readback", mem_model[i], vecs[v].words[i]);
        end

        // Oversize header: 0x1001 words exceeds the 4096-word memory.
        w0 = writes;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h10, 1'b0);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_busy", 32'(busy), 32'd0);
        check("oversize_cpu_reset", 32'(cpu_reset), 32'd1);
        check("oversize_no_write", 32'(writes - w0), 32'd0);

        // Reset in the middle of a word: partial word must never be written.
        w0 = writes;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (4) @(negedge clk);
        check("midrst_no_write", 32'(writes - w0), 32'd0);
        wq = {};
        wq.push_back(32'h12345678);
        pulse_start();
        send_stream(16'd1, 1'b0, 1'b0);
        wait_idle();
        check("after_rst_done", 32'(done), 32'd1);
        check("after_rst_mem0", mem_model[0], 32'h12345678);

        // Start and reset together from DONE: reset wins, loader sits in IDLE.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        check("rst_wins_done", 32'(done), 32'd0);

        // A start pulse in the middle of a word is ignored.
        w0 = writes;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        sb.push_back('{addr: 32'h0, data: 32'hCAFEF00D});
        send_byte(8'h0D, 1'b0);
        pulse_start();
        send_byte(8'hF0, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hCA, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hC9, 1'b0);
`endif
        wait_idle();
        check("busy_start_done", 32'(done), 32'd1);
        check("busy_start_writes", 32'(writes - w0), 32'd1);

        // Full-depth image: 4096 words, last lands at 0x3FFC without wrapping.
        wq = {};
        for (int i = 0; i < (1 << AW); i++) wq.push_back(32'(i) ^ 32'hA5A50000);
        w0 = writes;
        pulse_start();
        send_stream(16'h1000, 1'b0, 1'b0);
        wait_idle();
        check("full_done", 32'(done), 32'd1);
        check("full_writes", 32'(writes - w0), 32'd4096);
        check("full_last_addr", mem_addr, 32'h00003FFC);
        check("full_last_word", mem_model[(1<<AW)-1], 32'h00000FFF ^ 32'hA5A50000);
        check("full_first_word", mem_model[0], 32'hA5A50000);

`ifdef LOADER_CHECKSUM_EN
        wq = {};
        wq.push_back(32'h44332211);
        pulse_start();
        send_stream(16'd1, 1'b0, 1'b0);
        wait_idle();
        check("chk_good_done", 32'(done), 32'd1);
        check("chk_good_cpu_reset", 32'(cpu_reset), 32'd0);
        pulse_start();
        send_stream(16'd1, 1'b0, 1'b1);
        wait_idle();
        check("chk_bad_error", 32'(error), 32'd1);
        check("chk_bad_done", 32'(done), 32'd0);
        check("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
